// File: rtl/icache.sv
// Direct-mapped instruction cache with one 32-bit word per line.
// Hits answer one cycle after the request; misses fetch one word from the memory controller.
module icache #(
  parameter int INDEX_BITS = 8,
  parameter int ADDR_BITS  = 18
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        jp_wrong,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_valid,
  output logic [31:0] if_inst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_valid,
  input  logic [31:0] mem_data
);
  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = ADDR_BITS - INDEX_BITS - 2;

  typedef enum logic {IDLE, MISS} state_t;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [31:0]      data;
  } line_t;

  state_t                  state, state_nxt;
  logic [LINES-1:0]        valid;
  line_t                   line_arr [LINES];

  logic [INDEX_BITS-1:0]   idx, fill_idx;
  logic [TAG_W-1:0]        tag, fill_tag;
  logic                    hit;
  logic                    fill_we;
  logic                    if_valid_nxt, mem_req_nxt;
  logic [31:0]             if_inst_nxt, mem_addr_nxt;
  logic                    unused_addr_lsb;

  assign idx      = if_addr[INDEX_BITS+1:2];
  assign tag      = if_addr[ADDR_BITS-1:INDEX_BITS+2];
  // The fill is addressed from the latched miss address, not the live fetch PC.
  assign fill_idx = mem_addr[INDEX_BITS+1:2];
  assign fill_tag = mem_addr[ADDR_BITS-1:INDEX_BITS+2];
  assign hit      = valid[idx] && (line_arr[idx].tag == tag);
  assign unused_addr_lsb = ^if_addr[1:0];

  always_comb begin
    state_nxt    = state;
    if_valid_nxt = 1'b0;
    if_inst_nxt  = if_inst;
    mem_req_nxt  = mem_req;
    mem_addr_nxt = mem_addr;
    fill_we      = 1'b0;
    if (jp_wrong) begin
      state_nxt   = IDLE;
      mem_req_nxt = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // The response cycle is dead: a new request is not taken while if_valid is high.
          if (if_req && !if_valid) begin
            if (hit) begin
              if_valid_nxt = 1'b1;
              if_inst_nxt  = line_arr[idx].data;
            end else begin
              mem_req_nxt  = 1'b1;
              mem_addr_nxt = {if_addr[31:2], 2'b00};
              state_nxt    = MISS;
            end
          end
        end
        MISS: begin
          if (mem_valid) begin
            fill_we      = 1'b1;
            if_valid_nxt = 1'b1;
            if_inst_nxt  = mem_data;
            mem_req_nxt  = 1'b0;
            state_nxt    = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      valid    <= '0;
      if_valid <= 1'b0;
      if_inst  <= '0;
      mem_req  <= 1'b0;
      mem_addr <= '0;
    end else if (rdy) begin
      state    <= state_nxt;
      if_valid <= if_valid_nxt;
      if_inst  <= if_inst_nxt;
      mem_req  <= mem_req_nxt;
      mem_addr <= mem_addr_nxt;
      if (fill_we) valid[fill_idx] <= 1'b1;
    end
  end

  // Tag/data storage carries no reset; the valid bits alone gate hits.
  always_ff @(posedge clk) begin
    if (!rst && rdy && fill_we) line_arr[fill_idx] <= '{tag: fill_tag, data: mem_data};
  end

endmodule

// File: tb/tb_icache.sv
// Scoreboard bench for icache: stimulus pushes expected fetch words and miss
// addresses; a negedge monitor pops and compares whenever the DUT presents them.
module tb_icache;
  logic        clk = 1'b0;
  logic        rst, rdy, jp_wrong, if_req, mem_valid;
  logic [31:0] if_addr, mem_data;
  logic        if_valid, mem_req;
  logic [31:0] if_inst, mem_addr;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_inst_q [$];
  logic [31:0] exp_mem_q  [$];
  int          mem_starts = 0;
  logic        prev_mem_req = 1'b0;
  logic        resp_auto = 1'b1;
  int          resp_lat = 4;
  logic [31:0] mem_word = '0;

  icache dut (
    .clk(clk), .rst(rst), .rdy(rdy), .jp_wrong(jp_wrong),
    .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_inst(if_inst),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_valid(mem_valid), .mem_data(mem_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compares every response and every new miss request against the queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (if_valid) begin
        if (exp_inst_q.size() == 0) chk("unexpected_if_valid", if_inst, 32'hxxxx_xxxx);
        else chk("if_inst", if_inst, exp_inst_q.pop_front());
        chk("mem_req_with_if_valid", {31'b0, mem_req}, 32'd0);
      end
      if (mem_req && !prev_mem_req) begin
        mem_starts++;
        if (exp_mem_q.size() == 0) chk("unexpected_mem_req", mem_addr, 32'hxxxx_xxxx);
        else chk("mem_addr", mem_addr, exp_mem_q.pop_front());
      end
    end
    prev_mem_req = mem_req;
  end

  // Memory controller model: answers a request after resp_lat enabled cycles.
  initial begin
    mem_valid = 1'b0;
    mem_data  = '0;
    forever begin
      @(negedge clk);
      if (resp_auto && mem_req && !rst) begin
        for (int n = 0; n < resp_lat; ) begin
          @(negedge clk);
          if (rdy) n++;
        end
        if (resp_auto && mem_req) begin
          mem_valid = 1'b1;
          mem_data  = mem_word;
          @(negedge clk);
          mem_valid = 1'b0;
        end
      end
    end
  end

  task automatic fetch(input logic [31:0] addr, input logic [31:0] word, input bit miss, input string name);
    int starts0, cyc;
    bit seen;
    exp_inst_q.push_back(word);
    if (miss) exp_mem_q.push_back({addr[31:2], 2'b00});
    mem_word = word;
    @(negedge clk);
    starts0 = mem_starts;
    if_req  = 1'b1;
    if_addr = addr;
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      seen = if_valid;
    end
    if_req = 1'b0;
    if (!seen) begin
      errors++;
      $display("FAIL %s_timeout: no if_valid within 40 cycles", name);
      void'(exp_inst_q.pop_back());
    end
    chk({name, "_miss"}, mem_starts - starts0, miss ? 32'd1 : 32'd0);
    if (!miss) chk({name, "_hit_latency"}, cyc, 32'd1);
  endtask

  task automatic wait_mem_req(input string name);
    int cyc = 0;
    while (!mem_req && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    if (!mem_req) begin
      errors++;
      $display("FAIL %s: mem_req not raised within 20 cycles", name);
    end
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; jp_wrong = 1'b0; if_req = 1'b0; if_addr = '0;
    repeat (2) @(negedge clk);
    chk("rst_if_valid", {31'b0, if_valid}, 32'd0);
    chk("rst_mem_req",  {31'b0, mem_req},  32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_if_inst",  if_inst,  32'd0);
    rst = 1'b0;

    // 1 cold miss, 2 hit
    fetch(32'h0000, 32'h0000_0513, 1, "cold");
    fetch(32'h0000, 32'h0000_0513, 0, "hit0");
    // 3 conflict on index 0
    fetch(32'h0400, 32'h0010_0093, 1, "conf400");
    fetch(32'h0000, 32'h0000_0513, 1, "conf000");
    // bits above ADDR_BITS do not take part in the tag
    fetch(32'h0004_0000, 32'h0000_0513, 0, "alias");

    // 4 flush coincident with mem_valid
    resp_auto = 1'b0;
    exp_mem_q.push_back(32'h0008);
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h0008;
    @(negedge clk);
    wait_mem_req("flush_req");
    repeat (2) @(negedge clk);
    mem_valid = 1'b1; mem_data = 32'hDEAD_BEEF; jp_wrong = 1'b1; if_req = 1'b0;
    @(negedge clk);
    mem_valid = 1'b0; jp_wrong = 1'b0;
    chk("flush_if_valid", {31'b0, if_valid}, 32'd0);
    chk("flush_mem_req",  {31'b0, mem_req},  32'd0);
    repeat (3) @(negedge clk);
    resp_auto = 1'b1;
    fetch(32'h0008, 32'h0000_0113, 1, "after_flush");

    // 5 stall mid-miss; a mem_valid while frozen is ignored
    resp_auto = 1'b0;
    exp_mem_q.push_back(32'h000C);
    exp_inst_q.push_back(32'h2222_2222);
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h000C;
    @(negedge clk);
    wait_mem_req("stall_req");
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mem_valid = (i == 1); mem_data = 32'hBAD0_BAD0;
      @(negedge clk);
      chk("stall_mem_req",  {31'b0, mem_req},  32'd1);
      chk("stall_mem_addr", mem_addr, 32'h000C);
      chk("stall_if_valid", {31'b0, if_valid}, 32'd0);
    end
    mem_valid = 1'b0; rdy = 1'b1;
    @(negedge clk);
    chk("post_stall_mem_req", {31'b0, mem_req}, 32'd1);
    mem_valid = 1'b1; mem_data = 32'h2222_2222;
    @(negedge clk);
    mem_valid = 1'b0; if_req = 1'b0;
    chk("stall_fill_valid", {31'b0, if_valid}, 32'd1);
    resp_auto = 1'b1;
    fetch(32'h000C, 32'h2222_2222, 0, "stall_rehit");

    // 6 alignment, then reset clears the valid bits
    fetch(32'h0006, 32'h1111_1111, 1, "align");
    fetch(32'h0004, 32'h1111_1111, 0, "align_hit");
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst2_if_inst",  if_inst,  32'd0);
    chk("rst2_mem_addr", mem_addr, 32'd0);
    rst = 1'b0;
    fetch(32'h0004, 32'h1111_1111, 1, "post_rst");

    repeat (3) @(negedge clk);
    chk("inst_queue_empty", exp_inst_q.size(), 32'd0);
    chk("mem_queue_empty",  exp_mem_q.size(),  32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
